// File: rtl/mercury_pkg.sv
// Shared IFU types and defaults used by the fetch front end.
package mercury_pkg;

    // One instruction word as stored in the fetch FIFO
    typedef logic [31:0] fetch_entry_t;

    localparam logic [31:0] IFU_RESET_PC        = 32'h8000_0000;
    localparam int unsigned IFU_FIFO_DEPTH      = 4;
    localparam int unsigned IFU_MAX_OUTSTANDING = 2;

    typedef enum logic [1:0] {
        FC_BOOT,
        FC_FETCH,
        FC_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// imem request/response channel plus the fetch FIFO push/pop/flush lines.
interface ifu_fetch_ctrl_if;

    logic                      imem_req_valid;
    logic                      imem_req_ready;
    logic [31:0]               imem_req_addr;
    logic                      imem_rsp_valid;
    logic [31:0]               imem_rsp_data;
    logic                      fifo_push;
    mercury_pkg::fetch_entry_t fifo_entry;
    logic                      fifo_pop;
    logic                      fifo_flush;

    // fetch controller side
    modport master (
        output imem_req_valid,
        input  imem_req_ready,
        output imem_req_addr,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        output fifo_push,
        output fifo_entry,
        input  fifo_pop,
        output fifo_flush
    );

    // imem / FIFO side
    modport slave (
        input  imem_req_valid,
        output imem_req_ready,
        input  imem_req_addr,
        output imem_rsp_valid,
        output imem_rsp_data,
        input  fifo_push,
        input  fifo_entry,
        output fifo_pop,
        input  fifo_flush
    );

endinterface

// File: rtl/ifu_credit_ctr.sv
// Up/down credit counter with parallel load; up to two returns and one
// consume per cycle. Load has priority over counting.
module ifu_credit_ctr #(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned MAX_VAL  = 4,
    parameter int unsigned INIT_VAL = MAX_VAL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH+1:0] MAX_EXT = (WIDTH+2)'(MAX_VAL);

    logic [WIDTH+1:0] sum_ext;
    logic [WIDTH+1:0] dec_ext;
    logic [WIDTH+1:0] next_ext;

    // net sum computed two bits wider so over/underflow is visible to the check
    always_comb begin
        sum_ext  = {2'b00, count} + {{WIDTH{1'b0}}, inc};
        dec_ext  = {{(WIDTH+1){1'b0}}, dec};
        next_ext = sum_ext - dec_ext;
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= WIDTH'(INIT_VAL);
        end else if (load) begin
            count <= load_val;
        end else begin
            count <= next_ext[WIDTH-1:0];
        end
    end

    // credit must stay within 0..MAX_VAL
    always_ff @(posedge clk) begin
        if (rst) begin
            if (load) begin
                assert ({2'b00, load_val} <= MAX_EXT);
            end else begin
                assert ((sum_ext >= dec_ext) && (next_ext <= MAX_EXT));
            end
        end
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch front end: sequential PC generation, credit-limited imem issue,
// in-order response push into the fetch FIFO, redirect flush and drain.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FC_BOOT  | one idle cycle after reset, no request
//   FC_FETCH | issuing requests while credit and outstanding limit allow
//   FC_DRAIN | discarding responses of requests issued before a redirect
module ifu_fetch_ctrl
    import mercury_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH      = IFU_FIFO_DEPTH,
    parameter int unsigned MAX_OUTSTANDING = IFU_MAX_OUTSTANDING,
    parameter logic [31:0] RESET_PC        = IFU_RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    ifu_fetch_ctrl_if.master        bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned DW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);

    fetch_state_e state_q, state_d;

    logic [31:0]   pc_q;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_next;
    logic [DW-1:0] drop_q;
    logic [CW-1:0] credit;
    fetch_entry_t  rsp_data_q;
    logic          push_q;
    logic          flush_q;

    logic          accept;
    logic          rsp_keep;
    logic          rsp_drop;
    logic [1:0]    credit_inc;
    logic [CW-1:0] credit_load_val;

    // handshake events and the outstanding count after this cycle
    always_comb begin
        accept          = bus.imem_req_valid & bus.imem_req_ready;
        rsp_drop        = bus.imem_rsp_valid & (drop_q != '0);
        rsp_keep        = bus.imem_rsp_valid & (drop_q == '0);
        inflight_next   = inflight_q + CW'(accept) - CW'(bus.imem_rsp_valid);
        credit_inc      = {1'b0, bus.fifo_pop} + {1'b0, rsp_drop};
        credit_load_val = DEPTH_C - inflight_next;
    end

    // a redirect reloads credit, ignoring any same-cycle pop
    ifu_credit_ctr #(
        .WIDTH    (CW),
        .MAX_VAL  (FIFO_DEPTH),
        .INIT_VAL (FIFO_DEPTH)
    ) u_credit (
        .clk      (clk),
        .rst      (rst),
        .load     (redirect_valid),
        .load_val (credit_load_val),
        .inc      (credit_inc),
        .dec      (accept),
        .count    (credit)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FC_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a redirect re-evaluates drain need from inflight_next
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FC_BOOT:  state_d = FC_FETCH;
            FC_FETCH: begin
                if (redirect_valid && (inflight_next != '0)) begin
                    state_d = FC_DRAIN;
                end
            end
            FC_DRAIN: begin
                if (redirect_valid) begin
                    state_d = (inflight_next != '0) ? FC_DRAIN : FC_FETCH;
                end else if (bus.imem_rsp_valid && (drop_q == DW'(1))) begin
                    state_d = FC_FETCH;
                end
            end
            default:  state_d = FC_BOOT;
        endcase
    end

    // FSM outputs; a redirect suppresses both issue and the pending push
    always_comb begin
        bus.imem_req_valid = (state_q == FC_FETCH) && (credit != '0) &&
                             (inflight_q < MAXO_C) && !redirect_valid;
        bus.imem_req_addr  = pc_q;
        bus.fifo_push      = push_q & ~redirect_valid;
        bus.fifo_entry     = rsp_data_q;
        bus.fifo_flush     = flush_q;
    end

    // PC, outstanding/drop tracking and the one-cycle response pipeline
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            rsp_data_q <= '0;
            push_q     <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            inflight_q <= inflight_next;
            flush_q    <= redirect_valid;
            if (rsp_keep) begin
                rsp_data_q <= bus.imem_rsp_data;
            end
            if (redirect_valid) begin
                pc_q   <= redirect_pc & 32'hFFFF_FFFC;
                drop_q <= DW'(inflight_next);
                push_q <= 1'b0;
            end else begin
                if (accept) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (rsp_drop) begin
                    drop_q <= drop_q - DW'(1);
                end
                push_q <= rsp_keep;
            end
        end
    end

endmodule
